// File: rtl/leitor_saida.sv
// leitor_saida: snapshots the output register bank and streams each entry,
// tagged with its index, over a valid/ready handshake to defuzzification.
module leitor_saida #(
  parameter int LARGURA   = 8,
  parameter int N_SAIDAS  = 3,
  parameter int PULA_ZERO = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inicio,
  input  logic [N_SAIDAS*LARGURA-1:0] entradas,
  input  logic                        pronto,
  output logic [LARGURA-1:0]          dado_out,
  output logic [3:0]                  codigo_out,
  output logic                        valido,
  output logic                        ocupado,
  output logic                        fim
);

  typedef enum logic [1:0] {
    OCIOSO,
    CARGA,
    ENVIO,
    FIM
  } estado_t;

  estado_t estado;
  estado_t prox;

  logic [3:0]         idx;
  logic [3:0]         idx_prox;
  logic [LARGURA-1:0] buffer [N_SAIDAS];
  logic [LARGURA-1:0] atual;
  logic [LARGURA-1:0] seguinte;
  logic               ultimo;
  logic               pula;
  logic               avanca;

  assign idx_prox = idx + 4'd1;
  assign ultimo   = (idx == 4'(N_SAIDAS - 1));
  assign pula     = (PULA_ZERO != 0) && (atual == '0);
  // A zero entry being skipped advances without waiting for pronto.
  assign avanca   = (estado == ENVIO) && (pula || pronto);

  // Select the current and the following snapshot entries by index.
  always_comb begin
    atual    = '0;
    seguinte = '0;
    for (int i = 0; i < N_SAIDAS; i++) begin
      if (idx == 4'(i)) atual = buffer[i];
      if (idx_prox == 4'(i)) seguinte = buffer[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) estado <= OCIOSO;
    else     estado <= prox;
  end

  // Next-state logic.
  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO: if (inicio) prox = CARGA;
      CARGA:  prox = ENVIO;
      ENVIO:  if (avanca && ultimo) prox = FIM;
      FIM:    prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  // Snapshot buffer, index and registered output data.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      dado_out   <= '0;
      codigo_out <= '0;
      for (int i = 0; i < N_SAIDAS; i++) buffer[i] <= '0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (inicio) begin
            idx <= '0;
            for (int i = 0; i < N_SAIDAS; i++)
              buffer[i] <= entradas[i*LARGURA +: LARGURA];
          end
        end
        CARGA: begin
          dado_out   <= buffer[0];
          codigo_out <= '0;
        end
        ENVIO: begin
          if (avanca && !ultimo) begin
            idx        <= idx_prox;
            dado_out   <= seguinte;
            codigo_out <= idx_prox;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    valido  = 1'b0;
    ocupado = 1'b0;
    fim     = 1'b0;
    unique case (estado)
      OCIOSO: ;
      CARGA:  ocupado = 1'b1;
      ENVIO: begin
        ocupado = 1'b1;
        valido  = !pula;
      end
      FIM: begin
        ocupado = 1'b1;
        fim     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_leitor_saida.sv
// tb_leitor_saida: scoreboard bench driving one skip-disabled and one
// skip-enabled reader with the same directed stimulus.
module tb_leitor_saida;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inicio = 1'b0;
  logic        pronto = 1'b1;
  logic [23:0] entradas = '0;

  logic [7:0] d0, d1;
  logic [3:0] c0, c1;
  logic       v0, v1, o0, o1, f0, f1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        fim;
    logic [7:0]  d;
    logic [3:0]  c;
    logic [31:0] ciclo;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  logic       pv0 = 0, pv1 = 0, pp = 0, prst = 1;
  logic [7:0] pd0 = 0, pd1 = 0;
  logic [3:0] pc0 = 0, pc1 = 0;

  leitor_saida #(.LARGURA(8), .N_SAIDAS(3), .PULA_ZERO(0)) dut0 (
    .clk(clk), .rst(rst), .inicio(inicio), .entradas(entradas),
    .pronto(pronto), .dado_out(d0), .codigo_out(c0), .valido(v0),
    .ocupado(o0), .fim(f0)
  );

  leitor_saida #(.LARGURA(8), .N_SAIDAS(3), .PULA_ZERO(1)) dut1 (
    .clk(clk), .rst(rst), .inicio(inicio), .entradas(entradas),
    .pronto(pronto), .dado_out(d1), .codigo_out(c1), .valido(v1),
    .ocupado(o1), .fim(f1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nome, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cyc %0d)",
               nome, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic f, input logic [7:0] d,
                      input logic [3:0] c, input int ciclo);
    ev_t e;
    e.fim = f;
    e.d = d;
    e.c = c;
    e.ciclo = ciclo;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push2(input logic f, input logic [7:0] d,
                       input logic [3:0] c, input int ciclo);
    push(0, f, d, c, ciclo);
    push(1, f, d, c, ciclo);
  endtask

  task automatic pop_ev(input int k, output ev_t e, output bit ok);
    e = '0;
    ok = 0;
    if (k == 0) begin
      if (q0.size() > 0) begin
        e = q0.pop_front();
        ok = 1;
      end
    end else begin
      if (q1.size() > 0) begin
        e = q1.pop_front();
        ok = 1;
      end
    end
  endtask

  task automatic monitora(input int k, input logic v, input logic f,
                          input logic oc, input logic [7:0] d,
                          input logic [3:0] c, input logic pv,
                          input logic [7:0] pd, input logic [3:0] pc);
    ev_t e;
    bit ok;
    if (!rst) begin
      if (v && pronto) begin
        pop_ev(k, e, ok);
        if (!ok) begin
          checks++;
          errors++;
          $display("FAIL dut%0d unexpected transfer got %0h/%0h expected none",
                   k, d, c);
        end else begin
          chk($sformatf("dut%0d_kind", k), 32'(e.fim), 32'd0);
          chk($sformatf("dut%0d_dado", k), 32'(d), 32'(e.d));
          chk($sformatf("dut%0d_codigo", k), 32'(c), 32'(e.c));
          chk($sformatf("dut%0d_ciclo", k), cyc, e.ciclo);
        end
      end
      if (f) begin
        pop_ev(k, e, ok);
        if (!ok) begin
          checks++;
          errors++;
          $display("FAIL dut%0d unexpected fim got 1 expected 0", k);
        end else begin
          chk($sformatf("dut%0d_fim_kind", k), 32'(e.fim), 32'd1);
          chk($sformatf("dut%0d_fim_ciclo", k), cyc, e.ciclo);
          chk($sformatf("dut%0d_fim_ocupado", k), 32'(oc), 32'd1);
          chk($sformatf("dut%0d_fim_valido", k), 32'(v), 32'd0);
        end
      end
      if (pv && !pp && !prst) begin
        chk($sformatf("dut%0d_hold_valido", k), 32'(v), 32'd1);
        chk($sformatf("dut%0d_hold_dado", k), 32'(d), 32'(pd));
        chk($sformatf("dut%0d_hold_codigo", k), 32'(c), 32'(pc));
      end
    end
  endtask

  always @(negedge clk) begin
    monitora(0, v0, f0, o0, d0, c0, pv0, pd0, pc0);
    monitora(1, v1, f1, o1, d1, c1, pv1, pd1, pc1);
    pv0  <= v0;
    pv1  <= v1;
    pd0  <= d0;
    pd1  <= d1;
    pc0  <= c0;
    pc1  <= c1;
    pp   <= pronto;
    prst <= rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ate(input int alvo);
    while (cyc < alvo) tick();
  endtask

  task automatic zeros(input string nome);
    chk({nome, "_v0"}, 32'(v0), 32'd0);
    chk({nome, "_o0"}, 32'(o0), 32'd0);
    chk({nome, "_f0"}, 32'(f0), 32'd0);
    chk({nome, "_d0"}, 32'(d0), 32'd0);
    chk({nome, "_c0"}, 32'(c0), 32'd0);
    chk({nome, "_v1"}, 32'(v1), 32'd0);
    chk({nome, "_o1"}, 32'(o1), 32'd0);
    chk({nome, "_d1"}, 32'(d1), 32'd0);
  endtask

  task automatic push_basico(input int t0);
    push2(1'b0, 8'hC4, 4'd0, t0 + 2);
    push2(1'b0, 8'h80, 4'd1, t0 + 3);
    push2(1'b0, 8'h30, 4'd2, t0 + 4);
    push2(1'b1, 8'h00, 4'd0, t0 + 5);
  endtask

  initial begin
    int t0;
    tick();
    tick();
    rst = 1'b0;
    zeros("reset");

    // Basic sweep
    entradas = {8'h30, 8'h80, 8'hC4};
    tick();
    t0 = cyc;
    inicio = 1'b1;
    push_basico(t0);
    tick();
    inicio = 1'b0;
    chk("carga_ocupado", 32'(o0), 32'd1);
    chk("carga_valido", 32'(v0), 32'd0);
    ate(t0 + 6);
    chk("idle_ocupado0", 32'(o0), 32'd0);
    chk("idle_ocupado1", 32'(o1), 32'd0);
    chk("idle_dado_kept", 32'(d0), 32'h30);
    ate(t0 + 8);

    // Backpressure on entry 1
    t0 = cyc;
    inicio = 1'b1;
    push2(1'b0, 8'hC4, 4'd0, t0 + 2);
    push2(1'b0, 8'h80, 4'd1, t0 + 6);
    push2(1'b0, 8'h30, 4'd2, t0 + 7);
    push2(1'b1, 8'h00, 4'd0, t0 + 8);
    tick();
    inicio = 1'b0;
    tick();
    tick();
    pronto = 1'b0;
    tick();
    chk("stall_valido", 32'(v0), 32'd1);
    chk("stall_dado", 32'(d0), 32'h80);
    chk("stall_codigo", 32'(c0), 32'd1);
    tick();
    tick();
    pronto = 1'b1;
    ate(t0 + 11);

    // Zero skip, one zero entry
    entradas = {8'h55, 8'h00, 8'h12};
    t0 = cyc;
    inicio = 1'b1;
    push(0, 1'b0, 8'h12, 4'd0, t0 + 2);
    push(0, 1'b0, 8'h00, 4'd1, t0 + 3);
    push(0, 1'b0, 8'h55, 4'd2, t0 + 4);
    push(0, 1'b1, 8'h00, 4'd0, t0 + 5);
    push(1, 1'b0, 8'h12, 4'd0, t0 + 2);
    push(1, 1'b0, 8'h55, 4'd2, t0 + 4);
    push(1, 1'b1, 8'h00, 4'd0, t0 + 5);
    tick();
    inicio = 1'b0;
    ate(t0 + 3);
    chk("skip_valido1", 32'(v1), 32'd0);
    chk("skip_ocupado1", 32'(o1), 32'd1);
    chk("noskip_valido0", 32'(v0), 32'd1);
    ate(t0 + 8);

    // Zero skip, all entries zero
    entradas = '0;
    t0 = cyc;
    inicio = 1'b1;
    push(0, 1'b0, 8'h00, 4'd0, t0 + 2);
    push(0, 1'b0, 8'h00, 4'd1, t0 + 3);
    push(0, 1'b0, 8'h00, 4'd2, t0 + 4);
    push(0, 1'b1, 8'h00, 4'd0, t0 + 5);
    push(1, 1'b1, 8'h00, 4'd0, t0 + 5);
    tick();
    inicio = 1'b0;
    ate(t0 + 8);

    // Snapshot isolation and ignored start
    entradas = {8'h30, 8'h80, 8'hC4};
    t0 = cyc;
    inicio = 1'b1;
    push_basico(t0);
    tick();
    inicio = 1'b0;
    entradas = 24'hFFFFFF;
    tick();
    tick();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    ate(t0 + 10);
    entradas = {8'h30, 8'h80, 8'hC4};

    // Synchronous reset mid-sweep
    t0 = cyc;
    inicio = 1'b1;
    push2(1'b0, 8'hC4, 4'd0, t0 + 2);
    tick();
    inicio = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    pronto = 1'b0;
    tick();
    rst = 1'b0;
    pronto = 1'b1;
    zeros("abort");
    chk("abort_f1", 32'(f1), 32'd0);
    ate(t0 + 8);

    // Fresh sweep, reset glitch between edges is ignored
    t0 = cyc;
    inicio = 1'b1;
    push_basico(t0);
    tick();
    inicio = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    ate(t0 + 9);

    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
